// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the IR/GPR datapath.
// Drives imem handshake, IR latch and GPR/SGPR commit strobes.
module instr_sequencer #(
    parameter int              PC_W          = 16,
    parameter logic [PC_W-1:0] START_PC      = '0,
    parameter int              FETCH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic            gpr_we,
    output logic            mul_hi_sel,
    output logic            sgpr_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MULHI,
        S_ERR
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_d;
    logic [31:0]     ir_d;
    logic            err_d;
    logic            halt_q, halt_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [4:0] op;
    logic       op_legal;
    logic       op_mul;

    assign op       = ir[31:27];
    assign op_legal = (op <= 5'd4);
    assign op_mul   = (op == 5'd4);

    // Moore outputs decoded from state and IR only.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc;
    assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
    assign gpr_we     = (state_q == S_EXEC) && op_legal;
    assign sgpr_we    = (state_q == S_MULHI);
    assign mul_hi_sel = (state_q == S_MULHI);

    // State and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc      <= START_PC;
            ir      <= '0;
            err     <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            ir      <= ir_d;
            err     <= err_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the wait counter only runs while stalled in FETCH.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        ir_d    = ir;
        err_d   = err;
        halt_d  = halt_q;
        cnt_d   = '0;
        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    pc_d    = START_PC;
                    err_d   = 1'b0;
                    halt_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (halt_req) halt_d = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc + 1'b1;
                    state_d = S_EXEC;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (!op_legal) begin
                    err_d   = 1'b1;
                    halt_d  = 1'b0;
                    state_d = S_ERR;
                end else if (op_mul) begin
                    if (halt_req) halt_d = 1'b1;
                    state_d = S_MULHI;
                end else if (halt_q) begin
                    halt_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    halt_d  = halt_req;
                    state_d = S_FETCH;
                end
            end
            S_MULHI: begin
                if (halt_q) begin
                    halt_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    halt_d  = halt_req;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
